// File: rtl/tl_mem_pipe.sv
// Pipelined TileLink backing memory: fixed-latency in-order access with a credit-limited response FIFO.
// Define TL_MEM_MONITOR_EN to add the mon_* access-monitor ports and a per-access $display trace.
module tl_mem_pipe #(
    parameter int DATA_BYTES = 8,
    parameter int ADDR_BITS  = 32,
    parameter int DEPTH      = 1024,
    parameter int LATENCY    = 5,
    parameter int RSP_DEPTH  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_write,
    input  logic [ADDR_BITS-1:0]    req_addr,
    input  logic [DATA_BYTES*8-1:0] req_data,
    input  logic [DATA_BYTES-1:0]   req_mask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic                    rsp_write,
    output logic [DATA_BYTES*8-1:0] rsp_data,
    output logic                    rsp_error
`ifdef TL_MEM_MONITOR_EN
    ,
    output logic                    mon_valid,
    output logic                    mon_write,
    output logic [ADDR_BITS-1:0]    mon_addr,
    output logic [DATA_BYTES*8-1:0] mon_data,
    output logic [DATA_BYTES-1:0]   mon_mask
`endif
);

    localparam int DW    = DATA_BYTES * 8;
    localparam int OFF   = $clog2(DATA_BYTES);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    typedef struct packed {
        logic                  valid;
        logic                  write;
        logic [ADDR_BITS-1:0]  addr;
        logic [DW-1:0]         data;
        logic [DATA_BYTES-1:0] mask;
    } stage_t;

    typedef struct packed {
        logic          write;
        logic          error;
        logic [DW-1:0] data;
    } rsp_t;

    stage_t             pipe [LATENCY];
    logic [DW-1:0]      mem  [DEPTH];
    rsp_t               fifo [RSP_DEPTH];
    logic [PTR_W-1:0]   head, tail;
    logic [CNT_W-1:0]   count, occ;

    stage_t             last;
    logic               accept, pop, push;
    logic [ADDR_BITS-1:0] word_idx;
    logic [IDX_W-1:0]   mem_idx;
    logic               in_range;
    logic [DW-1:0]      cur_word, merged;
    rsp_t               push_entry;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Simulation memory image; reset deliberately leaves it alone.
    initial begin
        for (int i = 0; i < DEPTH; i++)
            mem[i] = {8'hAA, {(DW - 8){1'b0}}} | DW'(i);
    end

    // Credits cover both the delay line and the FIFO, so a push never finds the FIFO full.
    assign req_ready = (occ < CNT_W'(RSP_DEPTH));
    assign accept    = req_valid & req_ready;
    assign pop       = rsp_valid & rsp_ready;
    assign last      = pipe[LATENCY-1];
    assign push      = last.valid;

    always_comb begin
        word_idx = last.addr >> OFF;
        in_range = (word_idx < ADDR_BITS'(DEPTH));
        mem_idx  = word_idx[IDX_W-1:0];
        cur_word = in_range ? mem[mem_idx] : '0;
        merged   = cur_word;
        for (int b = 0; b < DATA_BYTES; b++)
            if (last.mask[b]) merged[b*8 +: 8] = last.data[b*8 +: 8];
        push_entry.write = last.write;
        push_entry.error = !in_range;
        push_entry.data  = !in_range ? '0 : (last.write ? merged : cur_word);
    end

    // NOTE: sequential state uses non-blocking assignments so every stage samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < LATENCY; i++) pipe[i] <= '0;
        end else begin
            pipe[0] <= '{accept, req_write, req_addr, req_data, req_mask};
            for (int i = 1; i < LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    // NOTE: memory and FIFO storage have no reset; only the control state that qualifies them does.
    always_ff @(posedge clk) begin
        if (push && last.write && in_range) mem[mem_idx] <= merged;
    end

    always_ff @(posedge clk) begin
        if (push) fifo[tail] <= push_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
            occ   <= '0;
        end else begin
            if (push) tail <= ptr_inc(tail);
            if (pop)  head <= ptr_inc(head);
            count <= count + CNT_W'(push) - CNT_W'(pop);
            occ   <= occ + CNT_W'(accept) - CNT_W'(pop);
        end
    end

    // Outputs come straight from the head entry and hold while stalled.
    assign rsp_valid = (count != '0);
    assign rsp_write = rsp_valid & fifo[head].write;
    assign rsp_error = rsp_valid & fifo[head].error;
    assign rsp_data  = rsp_valid ? fifo[head].data : '0;

`ifdef TL_MEM_MONITOR_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mon_valid <= 1'b0;
            mon_write <= 1'b0;
            mon_addr  <= '0;
            mon_data  <= '0;
            mon_mask  <= '0;
        end else begin
            mon_valid <= push;
            if (push) begin
                mon_write <= last.write;
                mon_addr  <= last.addr;
                mon_data  <= push_entry.data;
                mon_mask  <= last.mask;
                $display("[tl_mem_pipe] %s addr=%h data=%h mask=%h err=%0d",
                         last.write ? "WR" : "RD", last.addr, push_entry.data,
                         last.mask, !in_range);
            end
        end
    end
`endif

endmodule

// File: tb/tb_tl_mem_pipe.sv
// Directed bench for tl_mem_pipe: scoreboard of expected responses fed at request acceptance.
module tb_tl_mem_pipe;

    typedef struct packed {
        logic        write;
        logic        error;
        logic [63:0] data;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr;
    logic [63:0] req_data;
    logic [7:0]  req_mask;
    logic        rsp_valid, rsp_ready, rsp_write, rsp_error;
    logic [63:0] rsp_data;

    logic        s_req_valid, s_req_ready, s_req_write;
    logic [31:0] s_req_addr;
    logic [63:0] s_req_data;
    logic [7:0]  s_req_mask;
    logic        s_rsp_valid, s_rsp_ready, s_rsp_write, s_rsp_error;
    logic [63:0] s_rsp_data;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    exp_t        exp_q[$];
    exp_t        seen_q[$];
    logic [63:0] model_mem [int];
    bit          skip_model = 1'b0;
    int          acc_count = 0, rsp_total = 0;
    int          last_acc_cyc = 0, last_rsp_cyc = 0;
    logic [63:0] last_rsp_data;
    logic        last_rsp_error;
    int          s_rsp_total = 0, s_drops = 0, s_first_cyc = 0, s_last_cyc = 0;

    int          acc_idx;
    logic [63:0] acc_new;
    exp_t        acc_e, got_e, pop_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    tl_mem_pipe dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_data(req_data), .req_mask(req_mask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
        .rsp_data(rsp_data), .rsp_error(rsp_error)
    );

    tl_mem_pipe #(.RSP_DEPTH(8)) u_stream (
        .clk(clk), .rst(rst),
        .req_valid(s_req_valid), .req_ready(s_req_ready), .req_write(s_req_write),
        .req_addr(s_req_addr), .req_data(s_req_data), .req_mask(s_req_mask),
        .rsp_valid(s_rsp_valid), .rsp_ready(s_rsp_ready), .rsp_write(s_rsp_write),
        .rsp_data(s_rsp_data), .rsp_error(s_rsp_error)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] model_read(input int idx);
        if (model_mem.exists(idx)) return model_mem[idx];
        return {8'hAA, 56'h0} | 64'(idx);
    endfunction

    // Expected response computed when the request is seen accepted.
    always @(negedge clk) begin
        if (!rst && req_valid && req_ready && !skip_model) begin
            acc_idx = int'(req_addr >> 3);
            if (acc_idx >= 1024) begin
                acc_e = '{req_write, 1'b1, 64'h0};
            end else begin
                acc_new = model_read(acc_idx);
                if (req_write) begin
                    for (int b = 0; b < 8; b++)
                        if (req_mask[b]) acc_new[b*8 +: 8] = req_data[b*8 +: 8];
                    model_mem[acc_idx] = acc_new;
                end
                acc_e = '{req_write, 1'b0, acc_new};
            end
            exp_q.push_back(acc_e);
            last_acc_cyc = cyc + 1;
        end
        if (!rst && req_valid && req_ready) acc_count++;
    end

    always @(negedge clk) begin
        if (!rst && rsp_valid && rsp_ready) begin
            got_e = '{rsp_write, rsp_error, rsp_data};
            seen_q.push_back(got_e);
            last_rsp_cyc   = cyc;
            last_rsp_data  = rsp_data;
            last_rsp_error = rsp_error;
            rsp_total++;
            check("sb_pending", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                pop_e = exp_q.pop_front();
                check("sb_rsp", 64'({got_e.write, got_e.error}), 64'({pop_e.write, pop_e.error}));
                check("sb_data", got_e.data, pop_e.data);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && s_req_valid && !s_req_ready) s_drops++;
        if (!rst && s_rsp_valid && s_rsp_ready) begin
            if (s_rsp_total == 0) s_first_cyc = cyc;
            s_last_cyc = cyc;
            check("stream_data", s_rsp_data, {8'hAA, 56'h0} | 64'(s_rsp_total));
            check("stream_err", 64'(s_rsp_error), 64'd0);
            s_rsp_total++;
        end
    end

    // Called at posedge+1; returns at posedge+1 just after the accepting edge, valid still high.
    task automatic issue(input logic w, input logic [31:0] a, input logic [63:0] d, input logic [7:0] m);
        bit done = 1'b0;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_data  = d;
        req_mask  = m;
        for (int n = 0; n < 200 && !done; n++) begin
            @(negedge clk);
            if (req_ready) done = 1'b1;
            @(posedge clk);
            #1;
        end
        check("issue_accepted", 64'(done), 64'd1);
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) begin
            @(posedge clk);
            #1;
        end
        check("drain", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, base_total;

        rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_data = '0; req_mask = '0;
        rsp_ready = 1'b0;
        s_req_valid = 1'b0; s_req_write = 1'b0; s_req_addr = '0; s_req_data = '0; s_req_mask = '0;
        s_rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        @(negedge clk);
        check("rst_req_ready", 64'(req_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_write", 64'(rsp_write), 64'd0);
        check("rst_rsp_error", 64'(rsp_error), 64'd0);
        check("rst_rsp_data", rsp_data, 64'h0);
        check("rst_s_req_ready", 64'(s_req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Single read: value and exact latency.
        rsp_ready = 1'b1;
        issue(1'b0, 32'h10, 64'h0, 8'h00);
        req_valid = 1'b0;
        drain();
        check("read_data", last_rsp_data, 64'hAA00000000000002);
        check("read_error", 64'(last_rsp_error), 64'd0);
        check("read_latency", 64'(last_rsp_cyc - last_acc_cyc), 64'd5);

        // Back-pressure: only RSP_DEPTH credits with the response side stalled.
        rsp_ready = 1'b0;
        seen_q.delete();
        base = acc_count;
        req_write = 1'b0; req_data = '0; req_mask = '0;
        for (int n = 0; n < 10; n++) begin
            req_valid = (acc_count - base) < 8;
            req_addr  = 32'((acc_count - base) * 8);
            @(posedge clk);
            #1;
        end
        check("bp_accepted", 64'(acc_count - base), 64'd4);
        check("bp_req_ready", 64'(req_ready), 64'd0);
        rsp_ready = 1'b1;
        for (int n = 0; n < 60 && (acc_count - base) < 8; n++) begin
            req_valid = (acc_count - base) < 8;
            req_addr  = 32'((acc_count - base) * 8);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        check("bp_all_accepted", 64'(acc_count - base), 64'd8);
        drain();
        check("bp_rsp_count", 64'(seen_q.size()), 64'd8);
        if (seen_q.size() == 8)
            for (int i = 0; i < 8; i++)
                check("bp_order", seen_q[i].data, {8'hAA, 56'h0} | 64'(i));

        // Masked write then read of the same word on the next cycle.
        seen_q.delete();
        issue(1'b1, 32'h18, 64'h1122334455667788, 8'h0F);
        issue(1'b0, 32'h18, 64'h0, 8'h00);
        req_valid = 1'b0;
        drain();
        check("wr_rd_count", 64'(seen_q.size()), 64'd2);
        if (seen_q.size() == 2) begin
            check("wr_rsp_write", 64'(seen_q[0].write), 64'd1);
            check("wr_rsp_data", seen_q[0].data, 64'hAA00000055667788);
            check("rd_rsp_write", 64'(seen_q[1].write), 64'd0);
            check("rd_rsp_data", seen_q[1].data, 64'hAA00000055667788);
        end

        // Out-of-range write leaves memory untouched.
        seen_q.delete();
        issue(1'b1, 32'(1024 * 8), 64'hDEADBEEFCAFEF00D, 8'hFF);
        issue(1'b0, 32'h0, 64'h0, 8'h00);
        req_valid = 1'b0;
        drain();
        check("oor_count", 64'(seen_q.size()), 64'd2);
        if (seen_q.size() == 2) begin
            check("oor_error", 64'(seen_q[0].error), 64'd1);
            check("oor_data", seen_q[0].data, 64'h0);
            check("oor_read0_err", 64'(seen_q[1].error), 64'd0);
            check("oor_read0_data", seen_q[1].data, 64'hAA00000000000000);
        end

        // Streaming on the deeper-FIFO instance.
        s_rsp_ready = 1'b1;
        s_req_valid = 1'b1;
        for (int i = 0; i < 32; i++) begin
            s_req_addr = 32'(i * 8);
            @(posedge clk);
            #1;
        end
        s_req_valid = 1'b0;
        for (int n = 0; n < 50 && s_rsp_total < 32; n++) begin
            @(posedge clk);
            #1;
        end
        check("stream_count", 64'(s_rsp_total), 64'd32);
        check("stream_ready_drops", 64'(s_drops), 64'd0);
        check("stream_back_to_back", 64'(s_last_cyc - s_first_cyc), 64'd31);

        // Reset while a write is still in the delay line.
        skip_model = 1'b1;
        base_total = rsp_total;
        issue(1'b1, 32'h20, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        req_valid = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        skip_model = 1'b0;
        repeat (10) begin
            @(posedge clk);
            #1;
        end
        check("rst_flight_no_rsp", 64'(rsp_total - base_total), 64'd0);
        check("rst_flight_ready", 64'(req_ready), 64'd1);
        issue(1'b0, 32'h20, 64'h0, 8'h00);
        req_valid = 1'b0;
        drain();
        check("rst_flight_read", last_rsp_data, 64'hAA00000000000004);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/tl_mem_pipe.md
# tl_mem_pipe

Parametrised successor to the fixed single-request TileLink backing memory. It accepts one read or write per cycle on a valid/ready request channel and keeps up to `RSP_DEPTH` operations in flight. Each operation completes in order after a fixed `LATENCY`, and results are returned on a valid/ready response channel with back-pressure. It sits behind the TL slave adapter as the memory model for bench and integration runs.

## Interface
- `DATA_BYTES`, 8: bytes per word; data width is `DATA_BYTES*8`.
- `ADDR_BITS`, 32: byte-address width.
- `DEPTH`, 1024: number of words.
- `LATENCY`, 5: cycles from request acceptance to memory access; legal range 1..15.
- `RSP_DEPTH`, 4: response FIFO entries; this is also the maximum number of operations outstanding.
- `clk` in 1: clock; all logic is on the rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when `req_valid` and `req_ready` are both high at an edge.
- `req_write` in 1: 1 = write, 0 = read.
- `req_addr` in `ADDR_BITS`: byte address. Word index is `req_addr >> log2(DATA_BYTES)`; the low offset bits are ignored.
- `req_data` in `DATA_BYTES*8`: write data.
- `req_mask` in `DATA_BYTES`: byte-enable for writes.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed when `rsp_valid` and `rsp_ready` are both high at an edge.
- `rsp_write` out 1: echoes `req_write`.
- `rsp_data` out `DATA_BYTES*8`: read data, or the merged word after a write.
- `rsp_error` out 1: word index was >= `DEPTH`.

## Operation
- **Delay line.** `LATENCY` stages, each holding valid, write, addr, data and mask. An accepted request enters stage 1 and shifts one stage per cycle; the line never stalls.
- **Access at last stage.** When an entry leaves stage `LATENCY`:
  - Read: `mem[idx]` is pushed into the response FIFO.
  - Write: each byte with its `mask` bit set is merged into `mem[idx]`; the memory is updated and the merged word is pushed.
  - Out of range: nothing is accessed or written; the pushed entry has `rsp_data = 0` and `rsp_error = 1`.
- **Ordering.** All operations complete in acceptance order. A read accepted after a write to the same word returns the written data.
- **Credit counter.** `occ` = entries in flight in the delay line + FIFO count.
  - `req_ready = (occ < RSP_DEPTH)`. It is combinational from registered state only and is independent of `req_valid`.
  - An accept increments `occ`. A response pop decrements it, and the freed credit is visible from the next cycle.
  - Accept and pop in the same cycle leave `occ` unchanged.
  - Because of the credit limit, the FIFO can never overflow.
- **Memory initial contents** (simulation `initial`): `mem[i] = {8'hAA, zeros} | i`. Reset does not reinitialise memory.
- **Reset.**
  - Clears the delay line, the FIFO and `occ`.
  - In-flight writes not yet at the last stage are dropped; memory keeps its contents.

## Timing
- **Reset values:**
  - `req_ready` = 1 (after reset deasserts).
  - `rsp_valid`, `rsp_write` and `rsp_error` = 0.
  - `rsp_data` = 0.
- **Latency.** A request accepted at edge T is pushed into the FIFO at edge T+`LATENCY`. `rsp_valid` is high in the cycle after that edge. With `rsp_ready` held high and `LATENCY` = 5, the response appears 5 cycles after acceptance.
- **Throughput** is 1 op/cycle, provided `RSP_DEPTH` >= `LATENCY`+1. Smaller `RSP_DEPTH` throttles issue through `req_ready`.
- **FIFO.** FWFT. `rsp_*` are driven from the head register, and the outputs stay stable while `rsp_valid` is high and `rsp_ready` is low. Push and pop may happen in the same cycle, including when the FIFO is full.
- **Response order.** The FIFO is in order; head and tail pointers wrap modulo `RSP_DEPTH`.

## Configuration
- `TL_MEM_MONITOR_EN` defined adds monitor outputs:
  - Ports: `mon_valid`, `mon_write`, `mon_addr` (`ADDR_BITS`), `mon_data`, `mon_mask`.
  - `mon_valid` is a one-cycle pulse registered at the last-stage access. `mon_data` carries the read data or the merged write word.
  - All monitor outputs reset to 0.
  - A `$display` line is printed per completed access.
- Undefined: the monitor ports are absent and no `$display` is printed.

## Test plan
- **Single read.** Defaults; read at `0x10` with `rsp_ready`=1 -> `rsp_data` = `0xAA00000000000002`, `rsp_error`=0, `rsp_valid` exactly 5 cycles after accept.
- **Masked write then read.** Write `0x18` with data `0x1122334455667788`, mask `0x0F`; then read `0x18` on the next cycle -> write response `0xAA00000055667788`, then read response with the same value, in order.
- **Back-pressure.** `RSP_DEPTH`=4, `rsp_ready`=0; offer 8 reads of `0x0`..`0x38` -> exactly 4 accepted and `req_ready` drops to 0. Raise `rsp_ready` -> responses `...00`, `...01`, `...02`, `...03` in order, and the remaining 4 requests are accepted as credits free.
- **Out of range.** Write to `DEPTH*8` -> `rsp_error`=1 and `rsp_data`=0; a following read of `0x0` returns `0xAA00000000000000` unchanged.
- **Streaming.** `RSP_DEPTH`=8, `LATENCY`=5; 32 back-to-back reads with `rsp_ready`=1 -> `req_ready` never drops and 32 responses arrive on consecutive cycles.
- **Reset mid-flight.** Write `0x20` with data `0xFF..FF`, mask `0xFF`; assert `rst` 2 cycles later for 1 cycle -> no response. A subsequent read of `0x20` returns `0xAA00000000000004`.
